// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- instruction-fetch stage of the 32-bit MIPS pipeline.
//
// Holds the fetch PC, drives Address into a combinational instruction memory
// and captures {Instruction, PC+4} into the IF/ID register. Handles hazard
// stalls, branch/jump redirects (which flush IF/ID) and a HALT state entered
// when the halt encoding is fetched.
//
// Optional feature: define FETCH_PERF_EN to add the saturating performance
// counters FetchCount, StallCount and FlushCount.
//
// Ports
//   Clk, Reset       rising-edge clock, synchronous active-high reset
//   Stall            hold PC and IF/ID
//   BranchTaken      EX-stage branch taken, redirect to BranchTarget
//   Jump             ID-stage jump, redirect to JumpTarget
//   Instruction      instruction-memory read data for Address
//   Address          instruction-memory address (byte or word, see WORD_ADDR)
//   PC               current fetch PC
//   IfIdInstruction  IF/ID instruction (0 for a bubble)
//   IfIdPC4          IF/ID PC+4 of the captured instruction
//   IfIdValid        IF/ID holds a real instruction
//   Halted           fetch is halted
//
// state   | meaning
// --------+----------------------------------------------------------
// S_RUN   | fetching sequentially, PC advances by 4 each free cycle
// S_HALT  | halt word fetched; PC frozen, IF/ID fed bubbles
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
   parameter int          WORD_ADDR = 0
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   input  logic [31:0] Instruction,
   output logic [31:0] Address,
   output logic [31:0] PC,
   output logic [31:0] IfIdInstruction,
   output logic [31:0] IfIdPC4,
   output logic        IfIdValid,
   output logic        Halted
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] FetchCount,
   output logic [31:0] StallCount,
   output logic [31:0] FlushCount
`endif
);

   typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_nxt, instr_nxt, pc4_nxt;
   logic        valid_nxt;
   logic [31:0] pc_plus4;

   assign pc_plus4 = PC + 32'd4;

   // state / pipeline register
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state           <= S_RUN;
         PC              <= RESET_PC;
         IfIdInstruction <= 32'h0;
         IfIdPC4         <= 32'h0;
         IfIdValid       <= 1'b0;
      end else begin
         state           <= state_nxt;
         PC              <= pc_nxt;
         IfIdInstruction <= instr_nxt;
         IfIdPC4         <= pc4_nxt;
         IfIdValid       <= valid_nxt;
      end
   end

   // next state: branch beats jump (older instruction), any redirect beats stall
   always_comb begin
      state_nxt = state;
      pc_nxt    = PC;
      instr_nxt = IfIdInstruction;
      pc4_nxt   = IfIdPC4;
      valid_nxt = IfIdValid;
      if (BranchTaken || Jump) begin
         // masking keeps targets word aligned
         pc_nxt    = (BranchTaken ? BranchTarget : JumpTarget) & ~32'h3;
         instr_nxt = 32'h0;
         pc4_nxt   = 32'h0;
         valid_nxt = 1'b0;
         state_nxt = S_RUN;
      end else if (Stall) begin
         // everything holds
      end else if (state == S_RUN) begin
         instr_nxt = Instruction;
         pc4_nxt   = pc_plus4;
         valid_nxt = 1'b1;
         if (Instruction == HALT_WORD)
            state_nxt = S_HALT;
         else
            pc_nxt = pc_plus4;
      end else begin
         instr_nxt = 32'h0;
         pc4_nxt   = 32'h0;
         valid_nxt = 1'b0;
      end
   end

   // outputs
   always_comb begin
      Halted  = (state == S_HALT);
      Address = (WORD_ADDR != 0) ? {2'b00, PC[31:2]} : PC;
   end

`ifdef FETCH_PERF_EN
   logic redirect, stall_only, fetch_cap;

   assign redirect   = BranchTaken | Jump;
   assign stall_only = Stall & ~redirect;
   // a fresh capture is a valid load that is neither a hold nor a flush
   assign fetch_cap  = valid_nxt & ~Stall & ~redirect;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         FetchCount <= 32'h0;
         StallCount <= 32'h0;
         FlushCount <= 32'h0;
      end else begin
         if (fetch_cap && FetchCount != 32'hFFFF_FFFF)
            FetchCount <= FetchCount + 32'd1;
         if (stall_only && StallCount != 32'hFFFF_FFFF)
            StallCount <= StallCount + 32'd1;
         if (redirect && FlushCount != 32'hFFFF_FFFF)
            FlushCount <= FlushCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit -- directed bench for fetch_unit (default parameters).
// Instruction memory is a small bench-side table: address 0 holds
// 32'h2008_0005, address 16 holds the halt word when halt_en is set, and
// every other address returns 32'h2400_0000 | address.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   logic        Clk = 1'b0;
   logic        Reset, Stall, BranchTaken, Jump;
   logic [31:0] BranchTarget, JumpTarget, Instruction;
   logic [31:0] Address, PC, IfIdInstruction, IfIdPC4;
   logic        IfIdValid, Halted;
   logic        halt_en;
`ifdef FETCH_PERF_EN
   logic [31:0] FetchCount, StallCount, FlushCount;
`endif

   int vectors     = 0;
   int miscompares = 0;

   always #5 Clk = ~Clk;

   fetch_unit dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .Stall           (Stall),
      .BranchTaken     (BranchTaken),
      .BranchTarget    (BranchTarget),
      .Jump            (Jump),
      .JumpTarget      (JumpTarget),
      .Instruction     (Instruction),
      .Address         (Address),
      .PC              (PC),
      .IfIdInstruction (IfIdInstruction),
      .IfIdPC4         (IfIdPC4),
      .IfIdValid       (IfIdValid),
      .Halted          (Halted)
`ifdef FETCH_PERF_EN
      ,
      .FetchCount      (FetchCount),
      .StallCount      (StallCount),
      .FlushCount      (FlushCount)
`endif
   );

   always_comb begin
      if (Address == 32'h0)
         Instruction = 32'h2008_0005;
      else if (halt_en && Address == 32'h10)
         Instruction = 32'hFFFF_FFFF;
      else
         Instruction = 32'h2400_0000 | Address;
   end

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] pc4, input logic vld, input logic hlt);
      chk_val({tag, ".pc"},    PC, pc);
      chk_val({tag, ".addr"},  Address, pc);
      chk_val({tag, ".instr"}, IfIdInstruction, ins);
      chk_val({tag, ".pc4"},   IfIdPC4, pc4);
      chk_val({tag, ".valid"}, {31'h0, IfIdValid}, {31'h0, vld});
      chk_val({tag, ".halt"},  {31'h0, Halted}, {31'h0, hlt});
   endtask

   task automatic clear_ctl();
      Stall = 1'b0; BranchTaken = 1'b0; Jump = 1'b0;
      BranchTarget = 32'h0; JumpTarget = 32'h0;
   endtask

   initial begin
      Reset = 1'b1; halt_en = 1'b0;
      clear_ctl();
      step(); step();
      chk_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

      // first fetch
      Reset = 1'b0;
      step();
      chk_ifid("fetch0", 32'h4, 32'h2008_0005, 32'h4, 1'b1, 1'b0);
      step();
      chk_ifid("fetch4", 32'h8, 32'h2400_0004, 32'h8, 1'b1, 1'b0);

      // three stalled cycles at PC=8
      Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_ifid($sformatf("stall%0d", i), 32'h8, 32'h2400_0004, 32'h8, 1'b1, 1'b0);
      end
      Stall = 1'b0;
      step();
      chk_ifid("unstall", 32'hC, 32'h2400_0008, 32'hC, 1'b1, 1'b0);

      // branch + jump + stall together: branch wins
      BranchTaken = 1'b1; BranchTarget = 32'h40;
      Jump = 1'b1; JumpTarget = 32'h80; Stall = 1'b1;
      step();
      chk_ifid("brprio", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
      clear_ctl();
      step();
      chk_ifid("postbr", 32'h44, 32'h2400_0040, 32'h44, 1'b1, 1'b0);

      // misaligned jump target
      Jump = 1'b1; JumpTarget = 32'h103;
      step();
      chk_ifid("jalign", 32'h100, 32'h0, 32'h0, 1'b0, 1'b0);

      // PC wrap from the top of the address space
      clear_ctl();
      BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFC;
      step();
      chk_val("wrap.pre", PC, 32'hFFFF_FFFC);
      clear_ctl();
      step();
      chk_ifid("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0);

      // halt word at PC=16
      halt_en = 1'b1;
      Jump = 1'b1; JumpTarget = 32'h10;
      step();
      chk_val("tohalt.pc", PC, 32'h10);
      clear_ctl();
      step();
      chk_ifid("halt", 32'h10, 32'hFFFF_FFFF, 32'h14, 1'b1, 1'b1);
      step();
      chk_ifid("halted", 32'h10, 32'h0, 32'h0, 1'b0, 1'b1);
      Stall = 1'b1;
      step();
      chk_ifid("hstall", 32'h10, 32'h0, 32'h0, 1'b0, 1'b1);
      Stall = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h20;
      step();
      chk_ifid("unhalt", 32'h20, 32'h0, 32'h0, 1'b0, 1'b0);
      clear_ctl();
      step();
      chk_ifid("resume", 32'h24, 32'h2400_0020, 32'h24, 1'b1, 1'b0);

      // reset while halted and stalled
      Jump = 1'b1; JumpTarget = 32'h10;
      step();
      clear_ctl();
      step();
      chk_val("rehalt", {31'h0, Halted}, 32'h1);
      Reset = 1'b1; Stall = 1'b1;
      step();
      chk_ifid("hreset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef FETCH_PERF_EN
      chk_val("fetchcnt", FetchCount, 32'h0);
      chk_val("stallcnt", StallCount, 32'h0);
      chk_val("flushcnt", FlushCount, 32'h0);
`endif
      Reset = 1'b0; Stall = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
